// File: rtl/rob_pkg.sv
// rob_pkg: encodings shared by the reorder buffer and its helpers.
//   rob_kind_e : entry kind as carried on issue_kind / commit_kind
//   ROB_XLEN   : default data/PC width
package rob_pkg;

  typedef enum logic [1:0] {
    ROB_KIND_REG    = 2'd0,  // writes rd at commit
    ROB_KIND_BRANCH = 2'd1,  // checked for mispredict at commit
    ROB_KIND_STORE  = 2'd2,
    ROB_KIND_NOWB   = 2'd3   // result but no rd write
  } rob_kind_e;

  localparam int unsigned ROB_XLEN = 32;

endpackage

// File: rtl/rob_wb_merge.sv
// rob_wb_merge: combinational match of one entry id against all writeback
// channels. The lowest-indexed matching channel supplies value/taken.
//   wb_valid/wb_id/wb_value/wb_taken : packed writeback buses, port 0 in LSBs
//   id                               : entry id to look for
//   hit/value/taken                  : match flag and winning channel payload
module rob_wb_merge
  import rob_pkg::*;
#(
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned XLEN     = ROB_XLEN
) (
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*ID_W-1:0] wb_id,
  input  logic [WB_PORTS*XLEN-1:0] wb_value,
  input  logic [WB_PORTS-1:0]      wb_taken,
  input  logic [ID_W-1:0]          id,
  output logic                     hit,
  output logic [XLEN-1:0]          value,
  output logic                     taken
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    taken = 1'b0;
    for (int unsigned i = 0; i < WB_PORTS; i++) begin
      if (!hit && wb_valid[i] && (wb_id[i*ID_W +: ID_W] == id)) begin
        hit   = 1'b1;
        value = wb_value[i*XLEN +: XLEN];
        taken = wb_taken[i];
      end
    end
  end

endmodule

// File: rtl/rob_queue.sv
// rob_queue: reorder buffer. Allocates in program order, collects results
// from WB_PORTS writeback channels, commits one entry per cycle in order and
// raises a registered one-cycle flush with redirect PC on branch mispredict.
//   issue_*   : allocation request; tail_id/full/empty report occupancy
//   wb_*      : packed writeback channels (port 0 in LSBs)
//   commit_*  : head retirement, all zero when commit_valid is low
//   flush/flush_pc : registered pipeline clear and redirect target
//   q_id*/q_ready*/q_value* : operand lookup with same-cycle wb bypass
//   rdy       : global enable, freezes all state when low
// Optional: define ROB_PERF_CNT_EN to add saturating perf_commits (32 bit)
// and perf_flushes (16 bit) counters.
module rob_queue
  import rob_pkg::*;
#(
  parameter int unsigned ID_W     = 3,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned XLEN     = ROB_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_kind,
  input  logic                     issue_done,
  input  logic [XLEN-1:0]          issue_value,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_pred_taken,
  input  logic [XLEN-1:0]          issue_alt_pc,
  output logic [ID_W-1:0]          tail_id,
  output logic                     full,
  output logic                     empty,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*ID_W-1:0] wb_id,
  input  logic [WB_PORTS*XLEN-1:0] wb_value,
  input  logic [WB_PORTS-1:0]      wb_taken,
  output logic                     commit_valid,
  output logic [ID_W-1:0]          commit_id,
  output logic [1:0]               commit_kind,
  output logic [4:0]               commit_rd,
  output logic [XLEN-1:0]          commit_value,
  output logic                     flush,
  output logic [XLEN-1:0]          flush_pc,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]              perf_commits,
  output logic [15:0]              perf_flushes,
`endif
  input  logic [ID_W-1:0]          q_id1,
  input  logic [ID_W-1:0]          q_id2,
  output logic                     q_ready1,
  output logic                     q_ready2,
  output logic [XLEN-1:0]          q_value1,
  output logic [XLEN-1:0]          q_value2
);

  localparam int unsigned   DEPTH    = 1 << ID_W;
  localparam logic [ID_W-1:0] ID_ONE  = ID_W'(1);
  localparam logic [ID_W:0]   CNT_ONE = (ID_W+1)'(1);
  localparam logic [ID_W:0]   CNT_FULL = (ID_W+1)'(DEPTH);

  logic [ID_W-1:0]  head, tail;
  logic [ID_W:0]    count, count_nxt;
  logic [DEPTH-1:0] busy, done, pred_q, taken_q;
  rob_kind_e        kind_q  [DEPTH];
  logic [4:0]       rd_q    [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];
  logic [XLEN-1:0]  alt_q   [DEPTH];

  logic [DEPTH-1:0] ent_hit, ent_taken, wb_apply;
  logic [XLEN-1:0]  ent_value [DEPTH];
  logic             alloc, mispredict;

  logic             q1_hit, q2_hit, q1_taken_unused, q2_taken_unused;
  logic [XLEN-1:0]  q1_wb_value, q2_wb_value;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rob_wb_merge #(.WB_PORTS(WB_PORTS), .ID_W(ID_W), .XLEN(XLEN)) u_merge (
      .wb_valid (wb_valid),
      .wb_id    (wb_id),
      .wb_value (wb_value),
      .wb_taken (wb_taken),
      .id       (ID_W'(e)),
      .hit      (ent_hit[e]),
      .value    (ent_value[e]),
      .taken    (ent_taken[e])
    );
  end

  rob_wb_merge #(.WB_PORTS(WB_PORTS), .ID_W(ID_W), .XLEN(XLEN)) u_q1 (
    .wb_valid (wb_valid),
    .wb_id    (wb_id),
    .wb_value (wb_value),
    .wb_taken (wb_taken),
    .id       (q_id1),
    .hit      (q1_hit),
    .value    (q1_wb_value),
    .taken    (q1_taken_unused)
  );

  rob_wb_merge #(.WB_PORTS(WB_PORTS), .ID_W(ID_W), .XLEN(XLEN)) u_q2 (
    .wb_valid (wb_valid),
    .wb_id    (wb_id),
    .wb_value (wb_value),
    .wb_taken (wb_taken),
    .id       (q_id2),
    .hit      (q2_hit),
    .value    (q2_wb_value),
    .taken    (q2_taken_unused)
  );

  assign tail_id      = tail;
  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign commit_valid = rdy && !flush && busy[head] && done[head];
  assign mispredict   = commit_valid && (kind_q[head] == ROB_KIND_BRANCH) &&
                        (taken_q[head] != pred_q[head]);
  assign alloc        = rdy && issue_valid && !full && !flush;
  // Writebacks land only on busy entries and never during the flush cycle.
  assign wb_apply     = busy & ent_hit & {DEPTH{!flush}};

  always_comb begin
    count_nxt = count;
    if (alloc && !commit_valid)      count_nxt = count + CNT_ONE;
    else if (!alloc && commit_valid) count_nxt = count - CNT_ONE;
  end

  always_comb begin
    commit_id    = '0;
    commit_kind  = '0;
    commit_rd    = '0;
    commit_value = '0;
    if (commit_valid) begin
      commit_id    = head;
      commit_kind  = kind_q[head];
      commit_rd    = (kind_q[head] == ROB_KIND_REG) ? rd_q[head] : 5'd0;
      commit_value = value_q[head];
    end
  end

  always_comb begin
    q_ready1 = busy[q_id1] && (q1_hit || done[q_id1]);
    q_ready2 = busy[q_id2] && (q2_hit || done[q_id2]);
    q_value1 = !q_ready1 ? '0 : (q1_hit ? q1_wb_value : value_q[q_id1]);
    q_value2 = !q_ready2 ? '0 : (q2_hit ? q2_wb_value : value_q[q_id2]);
  end

  // Occupancy and flush control. Commit clears busy before allocation sets
  // it, so a slot freed and reused in one cycle ends busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      done     <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else if (rdy) begin
      flush <= mispredict;
      if (mispredict) begin
        flush_pc <= alt_q[head];
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        busy     <= '0;
        done     <= '0;
      end else begin
        done <= done | wb_apply;
        if (commit_valid) begin
          busy[head] <= 1'b0;
          head       <= head + ID_ONE;
        end
        if (alloc) begin
          busy[tail] <= 1'b1;
          done[tail] <= issue_done;
          tail       <= tail + ID_ONE;
        end
        count <= count_nxt;
      end
    end
  end

  // Entry payload; validity is tracked by busy/done so no reset needed.
  always_ff @(posedge clk) begin
    if (rdy && !mispredict) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (wb_apply[e]) begin
          value_q[e] <= ent_value[e];
          taken_q[e] <= ent_taken[e];
        end
      end
      if (alloc) begin
        kind_q[tail]  <= rob_kind_e'(issue_kind);
        rd_q[tail]    <= issue_rd;
        value_q[tail] <= issue_done ? issue_value : '0;
        pred_q[tail]  <= issue_pred_taken;
        taken_q[tail] <= 1'b0;
        alt_q[tail]   <= issue_alt_pc;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commits <= '0;
      perf_flushes <= '0;
    end else if (rdy) begin
      if (commit_valid && (perf_commits != '1)) perf_commits <= perf_commits + 32'd1;
      if (mispredict && (perf_flushes != '1))   perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_queue.sv
// tb_rob_queue: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a queue-based model of the ROB.
module tb_rob_queue;

  localparam int ID_W = 3;
  localparam int WB_PORTS = 2;
  localparam int XLEN = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst, rdy, issue_valid, issue_done, issue_pred_taken;
  logic [1:0] issue_kind;
  logic [XLEN-1:0] issue_value, issue_alt_pc;
  logic [4:0] issue_rd;
  logic [ID_W-1:0] tail_id;
  logic full, empty;
  logic [WB_PORTS-1:0] wb_valid, wb_taken;
  logic [WB_PORTS*ID_W-1:0] wb_id;
  logic [WB_PORTS*XLEN-1:0] wb_value;
  logic commit_valid;
  logic [ID_W-1:0] commit_id;
  logic [1:0] commit_kind;
  logic [4:0] commit_rd;
  logic [XLEN-1:0] commit_value;
  logic flush;
  logic [XLEN-1:0] flush_pc;
  logic [ID_W-1:0] q_id1, q_id2;
  logic q_ready1, q_ready2;
  logic [XLEN-1:0] q_value1, q_value2;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commits;
  logic [15:0] perf_flushes;
`endif

  rob_queue #(.ID_W(ID_W), .WB_PORTS(WB_PORTS), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_done(issue_done),
    .issue_value(issue_value), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .tail_id(tail_id), .full(full), .empty(empty),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_taken(wb_taken),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kind(commit_kind),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .flush(flush), .flush_pc(flush_pc),
`ifdef ROB_PERF_CNT_EN
    .perf_commits(perf_commits), .perf_flushes(perf_flushes),
`endif
    .q_id1(q_id1), .q_id2(q_id2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2)
  );

  initial forever #5 clk = ~clk;

  int checks;
  int failures;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // ---------------- reference model: program-ordered list of live entries
  typedef struct {
    logic [2:0]  id;
    logic [1:0]  kind;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] value;
    bit          pred;
    bit          taken;
    logic [31:0] alt;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  bit          m_flush;
  logic [31:0] m_flush_pc;
  logic [31:0] m_pc;
  logic [15:0] m_pf;
  bit          m_known;

  function automatic int find(logic [2:0] id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  function automatic void lookup(input logic [2:0] qid, output bit r, output logic [31:0] v);
    int idx;
    r = 0;
    v = '0;
    idx = find(qid);
    if (idx < 0) return;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && wb_id[p*ID_W +: ID_W] == qid) begin
        r = 1;
        v = wb_value[p*XLEN +: XLEN];
        return;
      end
    end
    if (mq[idx].done) begin
      r = 1;
      v = mq[idx].value;
    end
  endfunction

  function automatic bit model_commit();
    return rdy && !m_flush && mq.size() > 0 && mq[0].done;
  endfunction

  function automatic void check_outputs();
    bit cv, r;
    logic [31:0] v;
    if (!m_known) return;
    cv = model_commit();
    chk("tail_id", 64'(tail_id), 64'(m_tail));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("flush", 64'(flush), 64'(m_flush));
    chk("flush_pc", 64'(flush_pc), 64'(m_flush_pc));
    chk("commit_valid", 64'(commit_valid), 64'(cv));
    chk("commit_id", 64'(commit_id), cv ? 64'(mq[0].id) : 64'd0);
    chk("commit_kind", 64'(commit_kind), cv ? 64'(mq[0].kind) : 64'd0);
    chk("commit_rd", 64'(commit_rd), (cv && mq[0].kind == 2'd0) ? 64'(mq[0].rd) : 64'd0);
    chk("commit_value", 64'(commit_value), cv ? 64'(mq[0].value) : 64'd0);
    lookup(q_id1, r, v);
    chk("q_ready1", 64'(q_ready1), 64'(r));
    chk("q_value1", 64'(q_value1), 64'(v));
    lookup(q_id2, r, v);
    chk("q_ready2", 64'(q_ready2), 64'(r));
    chk("q_value2", 64'(q_value2), 64'(v));
`ifdef ROB_PERF_CNT_EN
    chk("perf_commits", 64'(perf_commits), 64'(m_pc));
    chk("perf_flushes", 64'(perf_flushes), 64'(m_pf));
`endif
  endfunction

  function automatic void model_update();
    bit cv, mis, alloc, old_flush;
    ent_t n;
    if (rst) begin
      mq.delete();
      m_tail = 0; m_flush = 0; m_flush_pc = '0; m_pc = '0; m_pf = '0;
      m_known = 1;
      return;
    end
    if (!m_known || !rdy) return;
    cv = model_commit();
    mis = cv && mq[0].kind == 2'd1 && mq[0].taken != mq[0].pred;
    alloc = issue_valid && mq.size() < DEPTH && !m_flush;
    old_flush = m_flush;
    if (cv && m_pc != 32'hFFFF_FFFF) m_pc++;
    if (mis && m_pf != 16'hFFFF) m_pf++;
    m_flush = mis;
    if (mis) begin
      m_flush_pc = mq[0].alt;
      mq.delete();
      m_tail = 0;
      return;
    end
    if (!old_flush) begin
      foreach (mq[i]) begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p] && wb_id[p*ID_W +: ID_W] == mq[i].id) begin
            mq[i].done = 1;
            mq[i].value = wb_value[p*XLEN +: XLEN];
            mq[i].taken = wb_taken[p];
            break;
          end
        end
      end
    end
    if (cv) void'(mq.pop_front());
    if (alloc) begin
      n.id = 3'(m_tail);
      n.kind = issue_kind;
      n.rd = issue_rd;
      n.done = issue_done;
      n.value = issue_done ? issue_value : 32'd0;
      n.pred = issue_pred_taken;
      n.taken = 0;
      n.alt = issue_alt_pc;
      mq.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endfunction

  // ---------------- stimulus helpers (called at negedge)
  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rdy = 1; issue_valid = 0; issue_kind = '0; issue_done = 0;
    issue_value = '0; issue_rd = '0; issue_pred_taken = 0; issue_alt_pc = '0;
    wb_valid = '0; wb_id = '0; wb_value = '0; wb_taken = '0;
    q_id1 = '0; q_id2 = '0;
  endtask

  task automatic issue(input logic [1:0] kind, input bit dn, input logic [31:0] val,
                       input logic [4:0] rd, input bit pred, input logic [31:0] alt);
    issue_valid = 1; issue_kind = kind; issue_done = dn; issue_value = val;
    issue_rd = rd; issue_pred_taken = pred; issue_alt_pc = alt;
  endtask

  task automatic wb(input int p, input logic [2:0] id, input logic [31:0] val, input bit tk);
    wb_valid[p] = 1'b1;
    wb_id[p*ID_W +: ID_W] = id;
    wb_value[p*XLEN +: XLEN] = val;
    wb_taken[p] = tk;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1;
    step();
    idle();
  endtask

  task automatic rand_inputs();
    logic [2:0] id;
    idle();
    rdy = ($urandom_range(9) != 0);
    rst = ($urandom_range(299) == 0);
    if (mq.size() < DEPTH && $urandom_range(1) == 1)
      issue(2'($urandom_range(3)), ($urandom_range(3) == 0), $urandom, 5'($urandom_range(31)),
            1'($urandom_range(1)), $urandom);
    for (int p = 0; p < WB_PORTS; p++) begin
      if ($urandom_range(1) == 1) begin
        if (mq.size() > 0 && $urandom_range(3) != 0) id = mq[$urandom_range(mq.size() - 1)].id;
        else id = 3'($urandom_range(7));
        wb(p, id, $urandom, 1'($urandom_range(1)));
      end
    end
    q_id1 = 3'($urandom_range(7));
    q_id2 = 3'($urandom_range(7));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_known = 0;
    idle();
    @(negedge clk);
    reset_dut();

    // reset state
    #1;
    chk("rst_tail", 64'(tail_id), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_cv", 64'(commit_valid), 64'd0);
    chk("rst_qr", 64'(q_ready1), 64'd0);

    // 9 completed REGs plus one mispredicting branch: 10 commits, 1 flush
    for (int k = 0; k < 9; k++) begin
      idle(); issue(2'd0, 1, 32'(k), 5'(k + 1), 0, '0); step();
    end
    idle(); issue(2'd1, 1, 32'd0, 5'd0, 1, 32'h40); step();
    idle(); #1;
    chk("br_cv", 64'(commit_valid), 64'd1);
    chk("br_kind", 64'(commit_kind), 64'd1);
    step();
    idle(); #1;
    chk("pf_flush", 64'(flush), 64'd1);
    chk("pf_flush_pc", 64'(flush_pc), 64'h40);
`ifdef ROB_PERF_CNT_EN
    chk("perf_commits10", 64'(perf_commits), 64'd10);
    chk("perf_flushes1", 64'(perf_flushes), 64'd1);
`endif
    step();

    // fill to full
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      idle(); issue(2'd0, 0, '0, 5'(i + 1), 0, '0); step();
      chk("fill_tail", 64'(tail_id), 64'((i + 1) % 8));
    end
    idle(); #1;
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_empty", 64'(empty), 64'd0);
    chk("fill_cv", 64'(commit_valid), 64'd0);

    // out-of-order writeback, in-order commit
    wb(0, 3'd2, 32'h22, 0); #1; chk("ooo_cv_a", 64'(commit_valid), 64'd0); step();
    idle(); wb(0, 3'd0, 32'h10, 0); #1; chk("ooo_cv_b", 64'(commit_valid), 64'd0); step();
    idle(); wb(0, 3'd1, 32'h11, 0); #1;
    chk("ooo_c0", 64'(commit_id), 64'd0); chk("ooo_v0", 64'(commit_value), 64'h10);
    step();
    idle(); #1;
    chk("ooo_c1", 64'(commit_id), 64'd1); chk("ooo_v1", 64'(commit_value), 64'h11);
    chk("ooo_rd1", 64'(commit_rd), 64'd2);
    step();
    idle(); #1;
    chk("ooo_c2", 64'(commit_id), 64'd2); chk("ooo_v2", 64'(commit_value), 64'h22);
    step();

    // same-cycle bypass and port priority
    idle(); wb(1, 3'd3, 32'hABCD, 0); q_id1 = 3'd3; #1;
    chk("byp_ready", 64'(q_ready1), 64'd1);
    chk("byp_value", 64'(q_value1), 64'hABCD);
    step();
    idle(); wb(0, 3'd4, 32'h1, 0); wb(1, 3'd4, 32'h2, 0); step();
    idle(); q_id2 = 3'd4; #1;
    chk("prio_ready", 64'(q_ready2), 64'd1);
    chk("prio_value", 64'(q_value2), 64'h1);
    chk("prio_commit", 64'(commit_value), 64'h1);
    step();

    // mispredict
    reset_dut();
    idle(); issue(2'd1, 0, '0, 5'd0, 0, 32'h100); step();
    for (int i = 0; i < 3; i++) begin
      idle(); issue(2'd0, 0, '0, 5'(5 + i), 0, '0); step();
    end
    idle(); wb(0, 3'd0, 32'd0, 1); step();
    idle(); issue(2'd0, 1, 32'h9, 5'd9, 0, '0); wb(1, 3'd1, 32'h55, 0); #1;
    chk("mis_cv", 64'(commit_valid), 64'd1);
    chk("mis_id", 64'(commit_id), 64'd0);
    step();
    idle(); wb(0, 3'd2, 32'h66, 0); q_id1 = 3'd2; #1;
    chk("mis_flush", 64'(flush), 64'd1);
    chk("mis_flush_pc", 64'(flush_pc), 64'h100);
    chk("mis_empty", 64'(empty), 64'd1);
    chk("mis_tail", 64'(tail_id), 64'd0);
    chk("mis_qr", 64'(q_ready1), 64'd0);
    step();
    idle(); wb(0, 3'd3, 32'h77, 0); q_id1 = 3'd3; #1;
    chk("mis_flush_off", 64'(flush), 64'd0);
    chk("mis_empty2", 64'(empty), 64'd1);
    chk("mis_qr2", 64'(q_ready1), 64'd0);
    step();

    // issue while full is dropped; issue+commit keeps count
    reset_dut();
    idle(); issue(2'd0, 0, '0, 5'd1, 0, '0); step();
    for (int i = 1; i < 8; i++) begin
      idle(); issue(2'd0, 1, 32'(32'h70 + i), 5'(i + 1), 0, '0); step();
    end
    idle(); #1;
    chk("full_full", 64'(full), 64'd1);
    wb(0, 3'd0, 32'h5, 0); issue(2'd0, 1, 32'h99, 5'd3, 0, '0); step();
    idle(); issue(2'd0, 1, 32'h98, 5'd3, 0, '0); #1;
    chk("full_cv", 64'(commit_valid), 64'd1);
    chk("full_val", 64'(commit_value), 64'h5);
    step();
    chk("full_drop_tail", 64'(tail_id), 64'd0);
    idle(); issue(2'd0, 0, '0, 5'd9, 0, '0); step();
    chk("full_swap_tail", 64'(tail_id), 64'd1);
    chk("full_swap_full", 64'(full), 64'd0);

    // rdy low freezes everything
    for (int i = 0; i < 5; i++) begin
      idle(); rdy = 0; #1;
      chk("rdy_cv", 64'(commit_valid), 64'd0);
      step();
      chk("rdy_tail", 64'(tail_id), 64'd1);
    end
    idle(); #1;
    chk("rdy_resume_id", 64'(commit_id), 64'd2);
    chk("rdy_resume_val", 64'(commit_value), 64'h72);
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
